// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide data memory with registered read data and no byte enables.
// Sub-word stores are performed as read-modify-write; faults are reported without touching memory.
module load_store_unit #(
    parameter int MEM_WORDS = 131072
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    state_t      state_reg;
    logic        op_we_reg;
    logic [2:0]  op_funct3_reg;
    logic [1:0]  op_lane_reg;
    logic [15:0] op_wdata_reg;

    logic illegal;
    logic misaligned;
    logic out_of_range;
    logic fault;
    logic is_sw;

    assign req_ready = (state_reg == IDLE);

    always_comb begin
        illegal      = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111)
                       || (req_we && req_funct3[2]);
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                       || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);
        fault        = illegal || misaligned || out_of_range;
        is_sw        = req_we && (req_funct3[1:0] == 2'b10);
    end

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {lane, 3'b000});
        h = 16'(word >> {lane[1], 4'b0000});
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [15:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] mask;
        logic [31:0] data;
        if (size == 2'b00) begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            data = {24'h0, wdata[7:0]} << {lane, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            data = {16'h0, wdata} << {lane[1], 4'b0000};
        end
        return (word & ~mask) | (data & mask);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            op_we_reg     <= 1'b0;
            op_funct3_reg <= 3'b000;
            op_lane_reg   <= 2'b00;
            op_wdata_reg  <= 16'h0;
            mem_a         <= 32'h0;
            mem_we        <= 1'b0;
            mem_wd        <= 32'h0;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'h0;
            resp_err      <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        op_we_reg     <= req_we;
                        op_funct3_reg <= req_funct3;
                        op_lane_reg   <= req_addr[1:0];
                        op_wdata_reg  <= req_wdata[15:0];
                        if (fault) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            state_reg  <= RESP;
                        end else begin
                            mem_a <= {req_addr[31:2], 2'b00};
                            if (is_sw) begin
                                mem_we    <= 1'b1;
                                mem_wd    <= req_wdata;
                                state_reg <= WRITE;
                            end else begin
                                state_reg <= READ;
                            end
                        end
                    end
                end
                WRITE: begin
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                    state_reg  <= RESP;
                end
                READ: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // mem_rd now holds the word addressed in READ.
                    if (op_we_reg) begin
                        mem_wd    <= merge_store(mem_rd, op_wdata_reg, op_funct3_reg[1:0], op_lane_reg);
                        mem_we    <= 1'b1;
                        state_reg <= WRITE;
                    end else begin
                        resp_rdata <= extend_load(mem_rd, op_funct3_reg, op_lane_reg);
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state_reg  <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
